dspl_mux_drv: RTL and testbench
===============================

Name: dspl_mux_drv

Overview:
Parametrised time-multiplexed driver for a common-anode 7-segment display bank. It is the successor to the fixed 8-digit driver and runs entirely in the system clock domain, using clock-enable counters instead of a derived clock. It adds over the fixed driver:
- configurable digit count and refresh rate
- per-digit blinking
- PWM brightness control
- an inter-digit guard band against ghosting
- a frame tick for upstream logic

It sits between the controller datapath and the board's an/cathode pins.

Parameters:
N_DIG, 8, number of digits, 1..16
DIG_PERIOD, 100000, clock cycles per digit slot (1 ms at 100 MHz), must be >= GUARD+2
GUARD, 4, cycles at slot start with all anodes off
BRIGHT_W, 3, brightness/PWM resolution in bits
BLINK_FRAMES, 64, full scan frames per blink half-period

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
digits  in  6*N_DIG  digit i at [6i+5:6i]: bit5 enable, bits4:1 hex code, bit0 decimal point (1 = lit)
blink_mask  in  N_DIG  bit i = 1 makes digit i blink
brightness  in  BRIGHT_W  0 = dimmest, all-ones = full on
an  out  N_DIG  anode enables, active low, registered
dec_cat  out  8  [7:1] = segments a..g, [0] = dp; active low, registered
frame_tick  out  1  one-cycle pulse on the first cycle of each slot 0

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high and is sampled on the clock edge like any other input.
- Reset values:
  - an = all ones; dec_cat = 8'hFF; frame_tick = 0.
  - slot_cnt = 0, idx = 0, frame_cnt = 0, blink_phase = 0 (visible).
  - Reset asserted mid-slot blanks the outputs at that edge. Scanning restarts at idx 0, slot_cnt 0 on the first cycle after release.
- Counters:
  - slot_cnt counts 0..DIG_PERIOD-1 and wraps.
  - On the wrap, idx advances 0..N_DIG-1 and wraps to 0.
  - On each idx wrap, frame_cnt advances 0..BLINK_FRAMES-1. At its wrap, blink_phase toggles.
  - Index and counter widths are derived with clog2.
- Sampling:
  - When slot_cnt == 0, digit idx's 6 bits are captured into cur_en, cur_code and cur_dp, and blink_mask[idx] into cur_blk.
  - Input changes mid-slot take effect at that digit's next slot.
- Visibility: vis = cur_en & ~(cur_blk & blink_phase).
- Anode drive:
  - pwm = (slot_cnt - GUARD) mod 2^BRIGHT_W.
  - active = (slot_cnt >= GUARD) & (pwm <= brightness) & vis.
  - brightness is sampled live, not latched per slot.
- Output registers (one clock latency from the slot_cnt/idx state):
  - an[idx] = ~active; all other an bits = 1. At most one anode is low in any cycle.
  - dec_cat = {font(cur_code), ~cur_dp} when active, else 8'hFF.
- Font, a..g active low:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- frame_tick: registered, high for exactly one cycle per frame, aligned with the first output cycle of slot 0.
- Duty cycle: brightness all-ones gives a full-on active window of DIG_PERIOD-GUARD cycles per slot. brightness b gives (b+1)/2^BRIGHT_W of that window, rounded by the mod pattern.
- N_DIG = 1: idx stays 0, and frame_tick pulses every slot.

Test Plan:
Bench parameters for all scenarios: N_DIG=4, DIG_PERIOD=16, GUARD=2, BRIGHT_W=2, BLINK_FRAMES=2.
1. Reset, then all digits enabled with codes 1,2,3,4, brightness=3 -> an cycles 1110, 1101, 1011, 0111.
   - Each slot: 2 cycles an=1111 and dec_cat=FF, then 14 cycles with the anode low.
   - Digit 0 shows dec_cat=10011111; frame_tick pulses every 64 cycles.
2. brightness=0 -> per slot, the anode is low only at slot_cnt 2, 6, 10, 14 (4 cycles); dec_cat=FF elsewhere.
3. blink_mask=0001 -> digit 0 is lit in frames 0-1 and dark (an[0]=1) in frames 2-3, giving a 256-cycle period. Digits 1-3 are unaffected.
4. Digit 2 enable=0 and dp=1 on digit 1 -> slot 2 is all-ones throughout. Slot 1 has dec_cat[0]=0.
5. Change digit 0's code from 8 to 5 at slot_cnt 7 of slot 0 -> the current slot still shows 8 (0000000); the next frame's slot 0 shows 5 (0100100).
6. Assert reset for 1 cycle mid-slot 2 -> the next output is an=1111 and dec_cat=FF. Scanning resumes at slot 0 with the guard band, and frame_tick fires on the first output cycle of slot 0.

Source files
------------

// File: rtl/dspl_mux_drv_if.sv
// Display bus between the controller datapath and the multiplexed driver.
interface dspl_mux_drv_if #(
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned BRIGHT_W = 3
);
  logic [6*N_DIG-1:0]  digits;
  logic [N_DIG-1:0]    blink_mask;
  logic [BRIGHT_W-1:0] brightness;
  logic [N_DIG-1:0]    an;
  logic [7:0]          dec_cat;
  logic                frame_tick;

  modport master (
    output digits, blink_mask, brightness,
    input  an, dec_cat, frame_tick
  );

  modport slave (
    input  digits, blink_mask, brightness,
    output an, dec_cat, frame_tick
  );
endinterface

// File: rtl/dspl_mux_drv.sv
// Time-multiplexed common-anode 7-segment driver with per-digit blink,
// PWM brightness, an inter-digit guard band and a frame tick.
module dspl_mux_drv #(
  parameter int unsigned N_DIG        = 8,
  parameter int unsigned DIG_PERIOD   = 100000,
  parameter int unsigned GUARD        = 4,
  parameter int unsigned BRIGHT_W     = 3,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic           clock,
  input  logic           reset,
  dspl_mux_drv_if.slave  bus
);

  localparam int unsigned SW = (DIG_PERIOD   > 1) ? $clog2(DIG_PERIOD)   : 1;
  localparam int unsigned IW = (N_DIG        > 1) ? $clog2(N_DIG)        : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIG_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [SW-1:0] GUARD_C    = SW'(GUARD);

  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                cur_en_q, cur_en_d;
  logic [3:0]          cur_code_q, cur_code_d;
  logic                cur_dp_q, cur_dp_d;
  logic                cur_blk_q, cur_blk_d;
  logic [N_DIG-1:0]    an_q, an_d;
  logic [7:0]          dec_cat_q, dec_cat_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_start;
  logic [5:0]          sel_dig;
  logic                sel_blk;
  logic                eff_en, eff_dp, eff_blk;
  logic [3:0]          eff_code;
  logic [BRIGHT_W-1:0] pwm;
  logic                vis;
  logic                active;

  function automatic logic [6:0] font(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Slot, digit-index, frame and blink-phase counters.
  always_comb begin
    slot_cnt_d    = slot_cnt_q + 1'b1;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Select the current digit's inputs and capture them at slot start.
  always_comb begin
    sel_dig = '0;
    sel_blk = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (idx_q == IW'(i)) begin
        sel_dig = bus.digits[6*i +: 6];
        sel_blk = bus.blink_mask[i];
      end
    end
    slot_start = (slot_cnt_q == '0);
    cur_en_d   = slot_start ? sel_dig[5]   : cur_en_q;
    cur_code_d = slot_start ? sel_dig[4:1] : cur_code_q;
    cur_dp_d   = slot_start ? sel_dig[0]   : cur_dp_q;
    cur_blk_d  = slot_start ? sel_blk      : cur_blk_q;
    // Slot-start cycle uses the live selection so GUARD = 0 still shows the new digit.
    eff_en   = cur_en_d;
    eff_code = cur_code_d;
    eff_dp   = cur_dp_d;
    eff_blk  = cur_blk_d;
  end

  // Anode/cathode drive: guard band, PWM window and blink visibility.
  always_comb begin
    pwm          = BRIGHT_W'(slot_cnt_q) - BRIGHT_W'(GUARD);
    vis          = eff_en & ~(eff_blk & blink_phase_q);
    active       = (slot_cnt_q >= GUARD_C) && (pwm <= bus.brightness) && vis;
    an_d         = '1;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (active && (idx_q == IW'(i))) an_d[i] = 1'b0;
    end
    dec_cat_d    = active ? {font(eff_code), ~eff_dp} : 8'hFF;
    frame_tick_d = slot_start && (idx_q == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      cur_en_q      <= 1'b0;
      cur_code_q    <= '0;
      cur_dp_q      <= 1'b0;
      cur_blk_q     <= 1'b0;
      an_q          <= '1;
      dec_cat_q     <= 8'hFF;
      frame_tick_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      cur_en_q      <= cur_en_d;
      cur_code_q    <= cur_code_d;
      cur_dp_q      <= cur_dp_d;
      cur_blk_q     <= cur_blk_d;
      an_q          <= an_d;
      dec_cat_q     <= dec_cat_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.dec_cat    = dec_cat_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dspl_mux_drv.sv
// Bench for dspl_mux_drv: directed scenarios plus random inputs, every
// output cycle compared with a time-indexed reference model.
module tb_dspl_mux_drv;

  localparam int N_DIG = 4;
  localparam int DP    = 16;
  localparam int GD    = 2;
  localparam int BW    = 2;
  localparam int BF    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dspl_mux_drv_if #(.N_DIG(N_DIG), .BRIGHT_W(BW)) bus ();

  dspl_mux_drv #(
    .N_DIG(N_DIG), .DIG_PERIOD(DP), .GUARD(GD),
    .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] font_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: state index s counts cycles since reset release.
  int         s = 0;
  logic       m_en = 1'b0, m_dp = 1'b0, m_blk = 1'b0;
  logic [3:0] m_code = '0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_cat = 8'hFF;
  logic       exp_ft = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    int sc, id, ph;
    logic act;
    logic [23:0] dg;
    @(posedge clk);
    dg = bus.digits;
    if (rst) begin
      exp_an = 4'hF; exp_cat = 8'hFF; exp_ft = 1'b0; s = 0;
    end else begin
      sc = s % DP;
      id = (s / DP) % N_DIG;
      ph = ((s / (DP * N_DIG)) / BF) % 2;
      if (sc == 0) begin
        m_en   = dg[6*id+5];
        m_code = dg[6*id+1 +: 4];
        m_dp   = dg[6*id];
        m_blk  = bus.blink_mask[id];
      end
      act = (sc >= GD) && (((sc - GD) % (1 << BW)) <= int'(bus.brightness))
            && m_en && !(m_blk && ph == 1);
      exp_an  = act ? ~(4'b0001 << id) : 4'hF;
      exp_cat = act ? {font_tab[m_code], ~m_dp} : 8'hFF;
      exp_ft  = (sc == 0) && (id == 0);
      s++;
    end
    #1;
    chk("an", {4'b0, bus.an}, {4'b0, exp_an});
    chk("dec_cat", bus.dec_cat, exp_cat);
    chk("frame_tick", {7'b0, bus.frame_tick}, {7'b0, exp_ft});
  endtask

  function automatic logic [23:0] pack(input logic [5:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    int cnt;
    bus.digits     = '0;
    bus.blink_mask = '0;
    bus.brightness = '0;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_an", {4'b0, bus.an}, 8'h0F);
    chk("reset_cat", bus.dec_cat, 8'hFF);

    // 1: codes 1,2,3,4 at full brightness
    bus.digits     = pack({1'b1, 4'h4, 1'b0}, {1'b1, 4'h3, 1'b0},
                          {1'b1, 4'h2, 1'b0}, {1'b1, 4'h1, 1'b0});
    bus.brightness = 2'd3;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (bus.frame_tick) cnt++;
      if (i == 3) chk("digit0_font", bus.dec_cat, 8'b10011111);
    end
    chk("frame_ticks_128", 8'(cnt), 8'd2);

    // 2: dimmest brightness -> 4 lit cycles per slot
    bus.brightness = 2'd0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.an != 4'hF) cnt++;
    end
    chk("dim_lit_cycles", 8'(cnt), 8'd16);

    // 3: blink digit 0
    bus.brightness = 2'd3;
    bus.blink_mask = 4'b0001;
    for (int i = 0; i < 512; i++) tick();

    // 4: digit 2 disabled, dp on digit 1
    bus.blink_mask = '0;
    bus.digits     = pack({1'b1, 4'h4, 1'b0}, {1'b0, 4'h3, 1'b0},
                          {1'b1, 4'h2, 1'b1}, {1'b1, 4'h8, 1'b0});
    for (int i = 0; i < 128; i++) tick();

    // 5: change digit 0 from 8 to 5 mid-slot
    for (int i = 0; i < 64 && !((s % DP) == 7 && ((s / DP) % N_DIG) == 0); i++) tick();
    chk("reach_slot0_mid", 8'(s % 64), 8'd7);
    bus.digits[5:0] = {1'b1, 4'h5, 1'b0};
    for (int i = 0; i < 128; i++) tick();

    // Random inputs
    for (int i = 0; i < 600; i++) begin
      if (i % 5 == 0) begin
        bus.digits     = {$urandom, $urandom} ;
        bus.blink_mask = 4'($urandom);
        bus.brightness = 2'($urandom);
      end
      tick();
    end

    // 6: one-cycle reset mid slot 2
    bus.digits     = pack({1'b1, 4'hF, 1'b1}, {1'b1, 4'hA, 1'b0},
                          {1'b1, 4'hB, 1'b0}, {1'b1, 4'h0, 1'b1});
    bus.blink_mask = '0;
    bus.brightness = 2'd3;
    for (int i = 0; i < 64 && !((s % DP) == 6 && ((s / DP) % N_DIG) == 2); i++) tick();
    chk("reach_slot2_mid", 8'(s % 64), 8'd38);
    rst = 1'b1;
    tick();
    chk("midreset_an", {4'b0, bus.an}, 8'h0F);
    chk("midreset_cat", bus.dec_cat, 8'hFF);
    rst = 1'b0;
    tick();
    chk("restart_tick", {7'b0, bus.frame_tick}, 8'd1);
    for (int i = 0; i < 100; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
